cnt4_udl: RTL and testbench

loadable up/down binary counter cell for the lsi_10k cell set. It is the registered source stage that drives IVP-class inverters and buffers.

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..16).
REQ-002 The module SHALL have port CP, input, 1 bit: the single clock; all state updates occur on the rising edge of CP.
REQ-003 The module SHALL have port CD, input, 1 bit: asynchronous active-low clear.
REQ-004 The module SHALL have port LD, input, 1 bit: synchronous parallel load, active-high.
REQ-005 The module SHALL have port EN, input, 1 bit: count enable, active-high.
REQ-006 The module SHALL have port UD, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-007 The module SHALL have port D, input, WIDTH bits: parallel load data.
REQ-008 The module SHALL have port Q, output, WIDTH bits: registered count.
REQ-009 The module SHALL have port QN, output, WIDTH bits: bitwise complement of Q.
REQ-010 The module SHALL have port TC, output, 1 bit: terminal count.

Function
REQ-011 At a rising CP edge with CD=1, the priority SHALL be LD > EN > hold.
REQ-012 LD=1 SHALL set Q <= D on that edge, regardless of EN and UD.
REQ-013 LD=0, EN=1, UD=1 SHALL set Q <= Q+1 modulo 2^WIDTH, so all-ones wraps to 0.
REQ-014 LD=0, EN=1, UD=0 SHALL set Q <= Q-1 modulo 2^WIDTH, so 0 wraps to all-ones.
REQ-015 LD=0, EN=0 SHALL hold Q unchanged.
REQ-016 Latency from any sampled control or D input to Q SHALL be exactly one CP edge; there is no pipelining.
REQ-017 TC SHALL be combinational: TC = EN & ~LD & ((UD & Q==all-ones) | (~UD & Q==0)).
- TC is high for the cycle before a wrap only.
- TC is usable to cascade a further stage's EN.
REQ-018 QN SHALL equal ~Q at all times, including during and after reset.
REQ-019 Changing UD in the same cycle as EN=1 SHALL take effect on that edge, using the sampled UD value; no extra cycle of old direction.
REQ-020 X or Z on LD, EN or UD at a CP edge with CD=1 SHALL drive Q to X.
- Simulation only; exposes uninitialized control.
REQ-021 The module SHALL contain a specify block.
- CP->Q and CP->QN full-connection edge delays as (best:typ:worst) rise, fall: rise 0.40:1.20:2.10 ns, fall 0.30:0.95:1.70 ns.
- CD->Q and CD->QN delays: 0.35:1.05:1.85 ns.
- Timing checks: $setup of D/LD/EN/UD to posedge CP = 0.50 ns; $hold = 0.20 ns; $width of CP high and low = 1.00 ns; $recovery of posedge CD to posedge CP = 0.60 ns.
- All values SHALL be held as specparams.
REQ-022 TC SHALL carry path delays of 0.25:0.80:1.40 ns from EN, UD and Q.

Reset
REQ-023 CD=0 SHALL immediately force Q=0, QN=all-ones, and TC = EN & ~LD & ~UD, independent of CP.
REQ-024 While CD=0, CP edges SHALL have no effect, including LD=1.
REQ-025 CD deasserting (0->1) SHALL not itself change Q.
- The first update is on the next qualifying CP edge.
REQ-026 CD asserting mid-count, including in the same timestep as a CP edge, SHALL win; Q ends at 0.

Verification (WIDTH=4)
REQ-027 Reset: CD=0 at t=0 with D=4'hA, LD=1, CP toggling -> Q=0, QN=4'hF throughout; release CD, one edge with LD=1 -> Q=4'hA.
REQ-028 Up wrap: load 4'hE, EN=1, UD=1 -> Q sequence E, F, 0, 1; TC=1 only while Q=F.
REQ-029 Down wrap: load 4'h1, EN=1, UD=0 -> Q sequence 1, 0, F, E; TC=1 only while Q=0.
REQ-030 Priority: Q=4'h5, LD=1, D=4'h9, EN=1, UD=1 -> Q=9, not 6; next edge with LD=0, EN=0 -> Q holds 9.
REQ-031 Async clear mid-count: counting up at Q=7, pull CD low between edges -> Q=0 within the CD->Q delay without a CP edge; CD high for 3 edges with EN=1, UD=1 -> Q=1, 2, 3.
REQ-032 Cascade: two instances, lower TC driving upper EN, both UD=1, start 8'h0E -> combined count 0E, 0F, 10, 11; run 8'hFF -> 00 with both TCs high at FF.

---
 rtl/cnt4_udl.sv | 79 +++++++
 tb/tb_cnt4_udl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cnt4_udl.sv
// Loadable up/down binary counter cell with asynchronous active-low clear.
// TC flags the cycle before a wrap so it can feed the EN of a further stage.
`timescale 1ns/1ps
module cnt4_udl #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             LD,
    input  logic             EN,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (LD) begin
            q_next = D;
        end else if (EN) begin
            if (UD) begin
                q_next = q_reg + ONE;
            end else begin
                q_next = q_reg - ONE;
            end
        end
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            q_reg <= '0;
        end else if ($isunknown({LD, EN, UD})) begin
            // Unknown control poisons the count so uninitialized drivers are visible.
            q_reg <= 'x;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q  = q_reg;
    assign QN = ~q_reg;
    assign TC = EN & ~LD & ((UD & (q_reg == ALL_ONES)) | (~UD & (q_reg == '0)));

    specify
        specparam t_cp_q_rise = 0.40:1.20:2.10;
        specparam t_cp_q_fall = 0.30:0.95:1.70;
        specparam t_cd_q      = 0.35:1.05:1.85;
        specparam t_tc        = 0.25:0.80:1.40;
        specparam t_setup     = 0.50;
        specparam t_hold      = 0.20;
        specparam t_width     = 1.00;
        specparam t_recovery  = 0.60;

        (CP *> Q, QN) = (t_cp_q_rise, t_cp_q_fall);
        (CD *> Q, QN) = t_cd_q;
        (EN, UD, Q *> TC) = t_tc;

        $setup(D,  posedge CP, t_setup);
        $setup(LD, posedge CP, t_setup);
        $setup(EN, posedge CP, t_setup);
        $setup(UD, posedge CP, t_setup);
        $hold(posedge CP, D,  t_hold);
        $hold(posedge CP, LD, t_hold);
        $hold(posedge CP, EN, t_hold);
        $hold(posedge CP, UD, t_hold);
        $width(posedge CP, t_width);
        $width(negedge CP, t_width);
        $recovery(posedge CD, posedge CP, t_recovery);
    endspecify

endmodule

// File: tb/tb_cnt4_udl.sv
// Directed bench for cnt4_udl: reset, vector table, async clear and a two-stage cascade.
`timescale 1ns/1ps
module tb_cnt4_udl;

    logic       cp;
    logic       cd;
    logic       ld;
    logic       en;
    logic       ud;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qn;
    logic       tc;

    logic       c_ld;
    logic       c_en;
    logic [7:0] c_d;
    logic [3:0] lo_q, lo_qn, hi_q, hi_qn;
    logic       lo_tc, hi_tc;

    int checks;
    int failures;

    cnt4_udl #(.WIDTH(4)) dut (
        .CP(cp), .CD(cd), .LD(ld), .EN(en), .UD(ud), .D(d),
        .Q(q), .QN(qn), .TC(tc)
    );

    cnt4_udl #(.WIDTH(4)) u_lo (
        .CP(cp), .CD(cd), .LD(c_ld), .EN(c_en), .UD(1'b1), .D(c_d[3:0]),
        .Q(lo_q), .QN(lo_qn), .TC(lo_tc)
    );

    cnt4_udl #(.WIDTH(4)) u_hi (
        .CP(cp), .CD(cd), .LD(c_ld), .EN(lo_tc), .UD(1'b1), .D(c_d[7:4]),
        .Q(hi_q), .QN(hi_qn), .TC(hi_tc)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [3:0] d;
        logic       exp_tc;   // TC before the edge
        logic [3:0] exp_q;    // Q after the edge
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end else begin
            $display("ok   %s value=%h", name, actual);
        end
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input logic [3:0] dv);
        @(negedge cp);
        ld = l;
        en = e;
        ud = u;
        d  = dv;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'hE, 1'b0, 4'hE};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'hF};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 4'h1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'hF};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'hE};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'h5};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 4'h9};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h9};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h8};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h9};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'hF};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'hF};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};

        // Reset held with a pending load and CP toggling.
        cd = 1'b0; ld = 1'b1; en = 1'b0; ud = 1'b1; d = 4'hA;
        c_ld = 1'b0; c_en = 1'b0; c_d = 8'h00;
        #1;
        check("reset_q_t0", {4'h0, q}, 8'h00);
        check("reset_qn_t0", {4'h0, qn}, 8'h0F);
        repeat (3) @(posedge cp);
        #1;
        check("reset_q_edges", {4'h0, q}, 8'h00);
        check("reset_qn_edges", {4'h0, qn}, 8'h0F);
        check("reset_tc_ld", {7'd0, tc}, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 4'hA);
        #1;
        check("reset_tc_down", {7'd0, tc}, 8'h01);
        @(posedge cp); #1;
        check("reset_q_no_count", {4'h0, q}, 8'h00);

        // Release between edges: no change until the next edge.
        drive(1'b1, 1'b0, 1'b1, 4'hA);
        cd = 1'b1;
        #1;
        check("release_q_hold", {4'h0, q}, 8'h00);
        @(posedge cp); #1;
        check("release_load", {4'h0, q}, 8'h0A);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].d);
            #1;
            check($sformatf("vec%0d_tc", i), {7'd0, tc}, {7'd0, vecs[i].exp_tc});
            @(posedge cp); #1;
            check($sformatf("vec%0d_q", i), {4'h0, q}, {4'h0, vecs[i].exp_q});
            check($sformatf("vec%0d_qn", i), {4'h0, qn}, {4'h0, ~vecs[i].exp_q});
        end

        // Async clear between edges while counting up at 7.
        drive(1'b1, 1'b0, 1'b1, 4'h6);
        @(posedge cp);
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        @(posedge cp); #1;
        check("clr_pre_q", {4'h0, q}, 8'h07);
        #1;
        cd = 1'b0;
        #2;
        check("clr_mid_q", {4'h0, q}, 8'h00);
        check("clr_mid_qn", {4'h0, qn}, 8'h0F);
        @(negedge cp);
        cd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge cp); #1;
            check($sformatf("clr_resume%0d", i), {4'h0, q}, i[7:0]);
        end

        // Clear asserted in the same timestep as a counting edge.
        @(posedge cp);
        cd = 1'b0;
        #1;
        check("clr_same_edge", {4'h0, q}, 8'h00);
        @(negedge cp);
        cd = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 4'h0);

        // Two-stage cascade.
        @(negedge cp);
        c_ld = 1'b1; c_en = 1'b0; c_d = 8'h0E;
        @(posedge cp); #1;
        check("casc_load", {hi_q, lo_q}, 8'h0E);
        @(negedge cp);
        c_ld = 1'b0; c_en = 1'b1;
        @(posedge cp); #1;
        check("casc_0f", {hi_q, lo_q}, 8'h0F);
        check("casc_lo_tc_0f", {7'd0, lo_tc}, 8'h01);
        @(posedge cp); #1;
        check("casc_10", {hi_q, lo_q}, 8'h10);
        @(posedge cp); #1;
        check("casc_11", {hi_q, lo_q}, 8'h11);
        @(negedge cp);
        c_ld = 1'b1; c_en = 1'b0; c_d = 8'hFF;
        @(posedge cp); #1;
        @(negedge cp);
        c_ld = 1'b0; c_en = 1'b1;
        #1;
        check("casc_ff_q", {hi_q, lo_q}, 8'hFF);
        check("casc_ff_tcs", {6'd0, hi_tc, lo_tc}, 8'h03);
        @(posedge cp); #1;
        check("casc_wrap", {hi_q, lo_q}, 8'h00);
        check("casc_wrap_qn", {hi_qn, lo_qn}, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
